// File: rtl/mem_channel_arbiter.sv
// Data-memory arbiter: hands pending LSU read/write requests to free memory channels and relays the result back.
// Optional macro ARBITER_ROUND_ROBIN_EN rotates scan priority; without it consumer 0 always scans first.
module mem_channel_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_CONSUMERS-1:0]                 consumer_read_request,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                 consumer_write_request,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]                  mem_read_request,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
   output logic [NUM_CHANNELS-1:0]                  mem_write_request,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);
   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                                 state   [NUM_CHANNELS];
   state_t                                 state_n [NUM_CHANNELS];
   logic [CW-1:0]                          cur     [NUM_CHANNELS];
   logic [CW-1:0]                          cur_n   [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]               claim, claim_n;
   logic [CW-1:0]                          rr_ptr, rr_ptr_n;
   logic                                   found;
   logic [CW-1:0]                          idx, pick;

   logic [NUM_CONSUMERS-1:0]               consumer_read_ready_n, consumer_write_ready_n;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_n;
   logic [NUM_CHANNELS-1:0]                mem_read_request_n, mem_write_request_n;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address_n, mem_write_address_n;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data_n;
`ifdef ARBITER_ROUND_ROBIN_EN
   logic                                   grant_any;
   logic [CW-1:0]                          grant_last;
`endif

   always_comb begin
      state_n                = state;
      cur_n                  = cur;
      claim_n                = claim;
      rr_ptr_n               = rr_ptr;
      found                  = 1'b0;
      idx                    = '0;
      pick                   = '0;
      consumer_read_ready_n  = consumer_read_ready;
      consumer_write_ready_n = consumer_write_ready;
      consumer_read_data_n   = consumer_read_data;
      mem_read_request_n     = mem_read_request;
      mem_write_request_n    = mem_write_request;
      mem_read_address_n     = mem_read_address;
      mem_write_address_n    = mem_write_address;
      mem_write_data_n       = mem_write_data;
`ifdef ARBITER_ROUND_ROBIN_EN
      grant_any              = 1'b0;
      grant_last             = '0;
`endif

      // Channels resolve in ascending order; claim_n carries lower-channel grants upward in the same cycle.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state[c])
            IDLE: begin
               found = 1'b0;
               pick  = '0;
               for (int k = 0; k < NUM_CONSUMERS; k++) begin
                  idx = CW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
                  if (!found && !claim_n[idx] &&
                      (consumer_read_request[idx] || consumer_write_request[idx])) begin
                     found = 1'b1;
                     pick  = idx;
                  end
               end
               if (found) begin
                  claim_n[pick] = 1'b1;
                  cur_n[c]      = pick;
`ifdef ARBITER_ROUND_ROBIN_EN
                  grant_any  = 1'b1;
                  grant_last = pick;
`endif
                  if (consumer_read_request[pick]) begin
                     mem_read_request_n[c] = 1'b1;
                     mem_read_address_n[c] = consumer_read_address[pick];
                     state_n[c]            = READ_WAITING;
                  end else begin
                     mem_write_request_n[c] = 1'b1;
                     mem_write_address_n[c] = consumer_write_address[pick];
                     mem_write_data_n[c]    = consumer_write_data[pick];
                     state_n[c]             = WRITE_WAITING;
                  end
               end
            end
            READ_WAITING: begin
               if (mem_read_ready[c]) begin
                  consumer_read_data_n[cur[c]]  = mem_read_data[c];
                  consumer_read_ready_n[cur[c]] = 1'b1;
                  mem_read_request_n[c]         = 1'b0;
                  state_n[c]                    = READ_RELAYING;
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready[c]) begin
                  consumer_write_ready_n[cur[c]] = 1'b1;
                  mem_write_request_n[c]         = 1'b0;
                  state_n[c]                     = WRITE_RELAYING;
               end
            end
            READ_RELAYING: begin
               if (!consumer_read_request[cur[c]]) begin
                  consumer_read_ready_n[cur[c]] = 1'b0;
                  claim_n[cur[c]]               = 1'b0;
                  state_n[c]                    = IDLE;
               end
            end
            WRITE_RELAYING: begin
               if (!consumer_write_request[cur[c]]) begin
                  consumer_write_ready_n[cur[c]] = 1'b0;
                  claim_n[cur[c]]                = 1'b0;
                  state_n[c]                     = IDLE;
               end
            end
            default: state_n[c] = IDLE;
         endcase
      end

`ifdef ARBITER_ROUND_ROBIN_EN
      if (grant_any) begin
         rr_ptr_n = (grant_last == CW'(NUM_CONSUMERS - 1)) ? '0 : grant_last + CW'(1);
      end
`else
      rr_ptr_n = '0;
`endif
   end

   // Every output is registered so reset clears the whole interface in one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state[c] <= IDLE;
            cur[c]   <= '0;
         end
         claim                <= '0;
         rr_ptr               <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
         mem_read_request     <= '0;
         mem_write_request    <= '0;
         mem_read_address     <= '0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
      end else begin
         state                <= state_n;
         cur                  <= cur_n;
         claim                <= claim_n;
         rr_ptr               <= rr_ptr_n;
         consumer_read_ready  <= consumer_read_ready_n;
         consumer_write_ready <= consumer_write_ready_n;
         consumer_read_data   <= consumer_read_data_n;
         mem_read_request     <= mem_read_request_n;
         mem_write_request    <= mem_write_request_n;
         mem_read_address     <= mem_read_address_n;
         mem_write_address    <= mem_write_address_n;
         mem_write_data       <= mem_write_data_n;
      end
   end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed handshake scenarios, a one-channel fairness instance,
// and randomized LSU traffic checked against a shadow memory and per-consumer scoreboard.
`timescale 1ns/1ps
module tb_mem_channel_arbiter;
   localparam int AB = 8, DB = 8, NC = 8, NCH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NC-1:0]          consumer_read_request, consumer_read_ready;
   logic [NC-1:0]          consumer_write_request, consumer_write_ready;
   logic [NC-1:0][AB-1:0]  consumer_read_address, consumer_write_address;
   logic [NC-1:0][DB-1:0]  consumer_read_data, consumer_write_data;
   logic [NCH-1:0]         mem_read_request, mem_read_ready, mem_write_request, mem_write_ready;
   logic [NCH-1:0][AB-1:0] mem_read_address, mem_write_address;
   logic [NCH-1:0][DB-1:0] mem_read_data, mem_write_data;

   logic [NC-1:0]          f_rd_req, f_rd_rdy, f_wr_req, f_wr_rdy;
   logic [NC-1:0][AB-1:0]  f_rd_addr, f_wr_addr;
   logic [NC-1:0][DB-1:0]  f_rd_data, f_wr_data;
   logic [0:0]             f_mrd_req, f_mrd_rdy, f_mwr_req, f_mwr_rdy;
   logic [0:0][AB-1:0]     f_mrd_addr, f_mwr_addr;
   logic [0:0][DB-1:0]     f_mrd_data, f_mwr_data;

   mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
      .clk(clk), .reset(reset),
      .consumer_read_request(consumer_read_request), .consumer_read_address(consumer_read_address),
      .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
      .consumer_write_request(consumer_write_request), .consumer_write_address(consumer_write_address),
      .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
      .mem_read_request(mem_read_request), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_request(mem_write_request), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready));

   mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut_fair (
      .clk(clk), .reset(reset),
      .consumer_read_request(f_rd_req), .consumer_read_address(f_rd_addr),
      .consumer_read_ready(f_rd_rdy), .consumer_read_data(f_rd_data),
      .consumer_write_request(f_wr_req), .consumer_write_address(f_wr_addr),
      .consumer_write_data(f_wr_data), .consumer_write_ready(f_wr_rdy),
      .mem_read_request(f_mrd_req), .mem_read_address(f_mrd_addr),
      .mem_read_ready(f_mrd_rdy), .mem_read_data(f_mrd_data),
      .mem_write_request(f_mwr_req), .mem_write_address(f_mwr_addr),
      .mem_write_data(f_mwr_data), .mem_write_ready(f_mwr_rdy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Memory model: returns mem_arr contents after a programmable delay, stores writes.
   logic [7:0] mem_arr [256];
   logic [7:0] ref_mem [256];
   int         mem_delay = 1;
   bit         mem_check = 1'b0;
   int         rd_cnt [NCH];
   int         wr_cnt [NCH];
   int         rd_dly [NCH];
   int         wr_dly [NCH];
   logic [7:0] pend_raddr [NC];
   logic [7:0] pend_waddr [NC];
   logic [7:0] pend_wdata [NC];

   initial begin
      mem_read_ready  = '0;
      mem_read_data   = '0;
      mem_write_ready = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            if (!mem_read_request[c]) begin
               mem_read_ready[c] = 1'b0;
               rd_cnt[c] = 0;
            end else if (!mem_read_ready[c]) begin
               if (rd_cnt[c] == 0) begin
                  rd_dly[c] = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
                  if (mem_check)
                     check("rd_addr", mem_read_address[c], pend_raddr[mem_read_address[c][7:5]]);
               end
               if (rd_cnt[c] >= rd_dly[c]) begin
                  mem_read_ready[c] = 1'b1;
                  mem_read_data[c]  = mem_arr[mem_read_address[c]];
               end else rd_cnt[c]++;
            end
            if (!mem_write_request[c]) begin
               mem_write_ready[c] = 1'b0;
               wr_cnt[c] = 0;
            end else if (!mem_write_ready[c]) begin
               if (wr_cnt[c] == 0)
                  wr_dly[c] = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
               if (wr_cnt[c] >= wr_dly[c]) begin
                  mem_write_ready[c] = 1'b1;
                  mem_arr[mem_write_address[c]] = mem_write_data[c];
                  if (mem_check) begin
                     check("wr_addr", mem_write_address[c], pend_waddr[mem_write_address[c][7:5]]);
                     check("wr_data", mem_write_data[c], pend_wdata[mem_write_address[c][7:5]]);
                  end
               end else wr_cnt[c]++;
            end
         end
      end
   end

   // Zero-delay memory for the one-channel instance.
   initial begin
      f_mrd_rdy  = '0;
      f_mrd_data = '0;
      f_mwr_rdy  = '0;
      forever begin
         @(negedge clk);
         f_mrd_rdy     = f_mrd_req;
         f_mrd_data[0] = f_mrd_addr[0] ^ 8'hFF;
         f_mwr_rdy     = f_mwr_req;
      end
   end

   task automatic wait_ready(input bit is_wr, input int i, input int limit);
      int n = 0;
      while ((is_wr ? consumer_write_ready[i] : consumer_read_ready[i]) == 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(is_wr ? "wr_ready_wait" : "rd_ready_wait",
            is_wr ? consumer_write_ready[i] : consumer_read_ready[i], 1);
   endtask

   int         done_cnt, ch4, ng, busy, n_done, dup;
   bit         prev;
   logic [7:0] grants [9];
   logic [7:0] a_tmp;
   int         cst [NC];
   int         gap [NC];
   int         wcnt [NC];
   logic [NC-1:0] seen;

   initial begin
      reset = 1'b1;
      consumer_read_request = '0; consumer_write_request = '0;
      consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
      f_rd_req = '0; f_wr_req = '0; f_rd_addr = '0; f_wr_addr = '0; f_wr_data = '0;
      for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a * 7 + 8'h13);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_mreq", {mem_read_request, mem_write_request}, 0);
      check("rst_crdy", {consumer_read_ready, consumer_write_ready}, 0);
      check("rst_maddr", mem_read_address | mem_write_address | mem_write_data, 0);
      check("rst_cdata", {31'd0, |consumer_read_data}, 0);

      // Single read: consumer 3, address 0x2A, memory answers 0x5C after one cycle.
      mem_delay = 1;
      mem_arr[8'h2A] = 8'h5C;
      consumer_read_address[3] = 8'h2A;
      consumer_read_request[3] = 1'b1;
      @(negedge clk);
      check("t1_mreq", mem_read_request, 4'b0001);
      check("t1_maddr", mem_read_address[0], 8'h2A);
      wait_ready(1'b0, 3, 10);
      check("t1_data", consumer_read_data[3], 8'h5C);
      check("t1_mreq_low", mem_read_request, 0);
      consumer_read_request[3] = 1'b0;
      @(negedge clk);
      check("t1_rdy_low", consumer_read_ready, 0);

      // Write: consumer 5 writes 0x77 to 0x10.
      consumer_write_address[5] = 8'h10;
      consumer_write_data[5]    = 8'h77;
      consumer_write_request[5] = 1'b1;
      @(negedge clk);
      check("t2_mwreq", mem_write_request, 4'b0001);
      check("t2_mwaddr", mem_write_address[0], 8'h10);
      check("t2_mwdata", mem_write_data[0], 8'h77);
      check("t2_mrreq", mem_read_request, 0);
      wait_ready(1'b1, 5, 10);
      check("t2_no_rdrdy", consumer_read_ready, 0);
      check("t2_mem", mem_arr[8'h10], 8'h77);
      consumer_write_request[5] = 1'b0;
      @(negedge clk);
      check("t2_rdy_low", consumer_write_ready, 0);

      // Oversubscription: five readers, four channels.
      mem_delay = 3;
      for (int i = 0; i < 5; i++) begin
         mem_arr[8'h40 + i] = 8'(8'hA0 + i);
         consumer_read_address[i] = 8'(8'h40 + i);
         consumer_read_request[i] = 1'b1;
      end
      @(negedge clk);
      check("t3_mreq", mem_read_request, 4'b1111);
      for (int c = 0; c < NCH; c++) check("t3_maddr", mem_read_address[c], 8'(8'h40 + c));
      done_cnt = 0;
      ch4 = -1;
      for (int cyc = 0; cyc < 60 && done_cnt < 5; cyc++) begin
         for (int c = 0; c < NCH; c++)
            if (mem_read_request[c] && mem_read_address[c] == 8'h44 && ch4 < 0) ch4 = c;
         for (int i = 0; i < 5; i++)
            if (consumer_read_request[i] && consumer_read_ready[i]) begin
               check("t3_data", consumer_read_data[i], 8'(8'hA0 + i));
               consumer_read_request[i] = 1'b0;
               done_cnt++;
            end
         @(negedge clk);
      end
      check("t3_done", done_cnt, 5);
      check("t3_ch4", ch4, 0);
      repeat (2) @(negedge clk);

      // Reset while three channels wait on memory.
      mem_delay = 50;
      for (int i = 0; i < 3; i++) begin
         consumer_read_address[i] = 8'(8'h50 + i);
         consumer_read_request[i] = 1'b1;
      end
      @(negedge clk);
      check("t4_mreq", mem_read_request, 4'b0111);
      reset = 1'b1;
      @(negedge clk);
      check("t4_mreq_rst", {mem_read_request, mem_write_request}, 0);
      check("t4_rdy_rst", {consumer_read_ready, consumer_write_ready}, 0);
      check("t4_addr_rst", mem_read_address, 0);
      reset = 1'b0;
      consumer_read_request = '0;
      @(negedge clk);
      check("t4_idle", mem_read_request, 0);
      mem_delay = 1;
      mem_arr[8'h33] = 8'h3C;
      consumer_read_address[6] = 8'h33;
      consumer_read_request[6] = 1'b1;
      @(negedge clk);
      check("t4_fresh_req", mem_read_request, 4'b0001);
      check("t4_fresh_addr", mem_read_address[0], 8'h33);
      wait_ready(1'b0, 6, 10);
      check("t4_fresh_data", consumer_read_data[6], 8'h3C);
      consumer_read_request[6] = 1'b0;
      @(negedge clk);

      // Read and write pending on the same consumer: read goes first.
      mem_arr[8'h21] = 8'h12;
      consumer_read_address[2]  = 8'h21;
      consumer_write_address[2] = 8'h22;
      consumer_write_data[2]    = 8'h99;
      consumer_read_request[2]  = 1'b1;
      consumer_write_request[2] = 1'b1;
      @(negedge clk);
      check("t5_rd_first", mem_read_request, 4'b0001);
      check("t5_no_wr", mem_write_request, 0);
      wait_ready(1'b0, 2, 10);
      check("t5_rdata", consumer_read_data[2], 8'h12);
      consumer_read_request[2] = 1'b0;
      wait_ready(1'b1, 2, 20);
      check("t5_wmem", mem_arr[8'h22], 8'h99);
      check("t5_rd_low", consumer_read_ready[2], 0);
      consumer_write_request[2] = 1'b0;
      repeat (2) @(negedge clk);

      // Fairness on a single channel with every consumer re-requesting.
      for (int i = 0; i < NC; i++) f_rd_addr[i] = 8'(i);
      f_rd_req = '1;
      prev = 1'b0;
      ng = 0;
      for (int cyc = 0; cyc < 300 && ng < 9; cyc++) begin
         @(negedge clk);
         if (f_mrd_req[0] && !prev) begin
            grants[ng] = f_mrd_addr[0];
            ng++;
         end
         prev = f_mrd_req[0];
         for (int i = 0; i < NC; i++) begin
            if (f_rd_req[i] && f_rd_rdy[i]) f_rd_req[i] = 1'b0;
            else if (!f_rd_req[i] && !f_rd_rdy[i]) f_rd_req[i] = 1'b1;
         end
      end
      check("fair_count", ng, 9);
      for (int k = 0; k < 9; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
         check("fair_order", grants[k], 8'(k % NC));
`else
         check("fair_order", grants[k], 8'd0);
`endif
      end
      f_rd_req = '0;
      repeat (3) @(negedge clk);

      // Randomized traffic; each consumer owns the address block whose top bits equal its index.
      for (int a = 0; a < 256; a++) begin
         mem_arr[a] = 8'($urandom);
         ref_mem[a] = mem_arr[a];
      end
      mem_delay = -1;
      mem_check = 1'b1;
      n_done = 0;
      for (int i = 0; i < NC; i++) begin
         cst[i] = 0;
         gap[i] = int'($urandom_range(0, 8));
         wcnt[i] = 0;
      end
      for (int cyc = 0; cyc < 4500; cyc++) begin
         @(negedge clk);
         seen = '0;
         dup = 0;
         for (int c = 0; c < NCH; c++) begin
            if (mem_read_request[c]) begin
               if (seen[mem_read_address[c][7:5]]) dup = 1;
               seen[mem_read_address[c][7:5]] = 1'b1;
            end
            if (mem_write_request[c]) begin
               if (seen[mem_write_address[c][7:5]]) dup = 1;
               seen[mem_write_address[c][7:5]] = 1'b1;
            end
         end
         check("uniq_grant", dup, 0);
         busy = 0;
         for (int i = 0; i < NC; i++) begin
            check("spur_rd", {31'd0, consumer_read_ready[i] && cst[i] != 1}, 0);
            check("spur_wr", {31'd0, consumer_write_ready[i] && cst[i] != 2}, 0);
            case (cst[i])
               0: begin
                  if (gap[i] > 0) gap[i]--;
                  else if (cyc < 3000) begin
                     a_tmp = {3'(i), 5'($urandom_range(0, 31))};
                     wcnt[i] = 0;
                     if ($urandom_range(0, 1) == 0) begin
                        pend_raddr[i] = a_tmp;
                        consumer_read_address[i] = a_tmp;
                        consumer_read_request[i] = 1'b1;
                        cst[i] = 1;
                     end else begin
                        pend_waddr[i] = a_tmp;
                        pend_wdata[i] = 8'($urandom);
                        consumer_write_address[i] = a_tmp;
                        consumer_write_data[i] = pend_wdata[i];
                        consumer_write_request[i] = 1'b1;
                        cst[i] = 2;
                     end
                  end
               end
               1: begin
                  if (consumer_read_ready[i]) begin
                     check("rnd_rdata", consumer_read_data[i], ref_mem[pend_raddr[i]]);
                     consumer_read_request[i] = 1'b0;
                     cst[i] = 0;
                     gap[i] = int'($urandom_range(4, 20));
                     n_done++;
                  end else if (++wcnt[i] > 1000) begin
                     check("rnd_timeout", wcnt[i], 0);
                     consumer_read_request[i] = 1'b0;
                     cst[i] = 0;
                  end
               end
               default: begin
                  if (consumer_write_ready[i]) begin
                     ref_mem[pend_waddr[i]] = pend_wdata[i];
                     check("rnd_wmem", mem_arr[pend_waddr[i]], pend_wdata[i]);
                     consumer_write_request[i] = 1'b0;
                     cst[i] = 0;
                     gap[i] = int'($urandom_range(4, 20));
                     n_done++;
                  end else if (++wcnt[i] > 1000) begin
                     check("rnd_timeout", wcnt[i], 0);
                     consumer_write_request[i] = 1'b0;
                     cst[i] = 0;
                  end
               end
            endcase
            if (cst[i] != 0) busy++;
         end
         if (cyc >= 3000 && busy == 0) break;
      end
      check("rnd_drained", busy, 0);
      check("rnd_activity", {31'd0, n_done > 50}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
